// File: rtl/f1_lights_delay.sv
// F1 start-light sequencer: eight lights step on at LIGHT_TICKS intervals, then hold for MIN_DELAY+prbs_in ticks before a go pulse.
// Outputs are registered apart from busy and prbs_en, which decode from the state; there is no backpressure, and ticks are consumed as they arrive.
module f1_lights_delay #(
  parameter int LIGHT_TICKS = 20,
  parameter int MIN_DELAY   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic       tick,
  input  logic [6:0] prbs_in,
  output logic       prbs_en,
  output logic [7:0] lights,
  output logic       busy,
  output logic       go
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_LIGHTS = 2'b01;
  localparam logic [1:0] S_HOLD   = 2'b10;

  localparam logic [7:0] TICK_LAST  = 8'(LIGHT_TICKS - 1);
  localparam logic [7:0] DELAY_BASE = 8'(MIN_DELAY);

  logic [1:0] r_state;
  logic [7:0] r_lights;
  logic [7:0] r_tick_cnt;
  logic [7:0] r_delay_cnt;
  logic       r_go;

  logic [1:0] w_state_nxt;
  logic [7:0] w_lights_nxt;
  logic [7:0] w_tick_cnt_nxt;
  logic [7:0] w_delay_cnt_nxt;
  logic       w_go_nxt;
  logic       w_tick_last;
  logic       w_delay_last;
  logic       w_bar_full;
  logic [7:0] w_delay_load;

  assign w_tick_last  = (r_tick_cnt == TICK_LAST);
  // <=1 rather than ==1 so a zero count can never wrap and stall in HOLD
  assign w_delay_last = (r_delay_cnt <= 8'd1);
  assign w_bar_full   = (r_lights == 8'hFF);
  assign w_delay_load = DELAY_BASE + {1'b0, prbs_in};

  always_comb begin
    w_state_nxt     = r_state;
    w_lights_nxt    = r_lights;
    w_tick_cnt_nxt  = r_tick_cnt;
    w_delay_cnt_nxt = r_delay_cnt;
    w_go_nxt        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_lights_nxt = 8'h00;
        if (trigger) begin
          w_state_nxt    = S_LIGHTS;
          w_lights_nxt   = 8'h01;
          w_tick_cnt_nxt = 8'd0;
        end
      end
      S_LIGHTS: begin
        if (tick) begin
          if (w_tick_last) begin
            w_tick_cnt_nxt = 8'd0;
            if (w_bar_full) begin
              w_state_nxt     = S_HOLD;
              w_delay_cnt_nxt = w_delay_load;
            end else begin
              w_lights_nxt = {r_lights[6:0], 1'b1};
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 8'd1;
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          if (w_delay_last) begin
            w_state_nxt     = S_IDLE;
            w_lights_nxt    = 8'h00;
            w_delay_cnt_nxt = 8'd0;
            w_go_nxt        = 1'b1;
          end else begin
            w_delay_cnt_nxt = r_delay_cnt - 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_lights_nxt    = 8'h00;
        w_tick_cnt_nxt  = 8'd0;
        w_delay_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lights    <= 8'h00;
      r_tick_cnt  <= 8'd0;
      r_delay_cnt <= 8'd0;
      r_go        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lights    <= w_lights_nxt;
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_delay_cnt <= w_delay_cnt_nxt;
      r_go        <= w_go_nxt;
    end
  end

  // The PRBS free-runs only while idle, so the captured value depends on operator timing
  assign prbs_en = (r_state == S_IDLE);
  assign busy    = (r_state == S_LIGHTS) || (r_state == S_HOLD);
  assign lights  = r_lights;
  assign go      = r_go;

endmodule

// File: doc/f1_lights_delay.md
F1_LIGHTS_DELAY -- requirements
Module: f1_lights_delay

Interface
REQ-001 Parameter LIGHT_TICKS, default 20: tick strobes each light is held before the next one lights (legal 1..255).
REQ-002 Parameter MIN_DELAY, default 16: fixed part of the random hold delay, in ticks (legal 1..128).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 trigger  input  1  start request, level-sampled; acted on only in IDLE.
REQ-006 tick  input  1  single-cycle timebase strobe, e.g. 1 ms.
REQ-007 prbs_in  input  7  current value of the upstream 7-bit PRBS generator.
REQ-008 prbs_en  output  1  advance enable to the PRBS generator.
REQ-009 lights  output  8  light bar, bit 0 lit first.
REQ-010 busy  output  1  high in LIGHTS or HOLD.
REQ-011 go  output  1  one-cycle pulse marking lights-out, the reaction-timer start.

Function
REQ-012 Three states SHALL exist: IDLE, LIGHTS, HOLD; all outputs are registered except prbs_en and busy, which decode from the state.
REQ-013 prbs_en SHALL be 1 in IDLE and 0 in LIGHTS and HOLD, so the captured value depends on operator timing.
REQ-014 In IDLE: lights=0, busy=0; ticks ignored; trigger=1 at an edge -> next state LIGHTS, lights=8'h01, tick_cnt=0.
REQ-015 trigger and tick both high in IDLE -> trigger wins; that tick is not counted.
REQ-016 In LIGHTS, each tick increments tick_cnt; a tick with tick_cnt==LIGHT_TICKS-1 -> tick_cnt=0 and, if lights!=8'hFF, lights <= {lights[6:0],1'b1}.
REQ-017 That same terminal tick with lights==8'hFF -> load delay_cnt = MIN_DELAY + prbs_in (8-bit, zero-extended, no overflow by REQ-002), next state HOLD; lights stay 8'hFF.
REQ-018 Total LIGHTS duration SHALL be exactly 8*LIGHT_TICKS ticks from entry.
REQ-019 In HOLD, each tick decrements delay_cnt; a tick with delay_cnt==1 -> next edge: lights=0, go=1, state IDLE.
REQ-020 HOLD duration SHALL be exactly MIN_DELAY + prbs_in ticks, range MIN_DELAY..MIN_DELAY+127.
REQ-021 go SHALL be high exactly one clk cycle, coincident with the first cycle of lights==0 and state IDLE; go=0 at all other times.
REQ-022 trigger in LIGHTS or HOLD SHALL be ignored; trigger held high through go -> a new sequence starts at the edge after go, i.e. the first IDLE edge.
REQ-023 tick low -> no counter or light change in any state; ticks on consecutive cycles SHALL each count.
REQ-024 The state encoding SHALL be safe: any illegal state returns to IDLE on the next edge with lights=0, go=0.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for clk, force: state IDLE, lights=0, go=0, busy=0, tick_cnt=0, delay_cnt=0; prbs_en=1.
REQ-026 rst asserted mid-LIGHTS or mid-HOLD SHALL abort the sequence with no go pulse.
REQ-027 After rst deasserts, the first edge behaves as IDLE; a trigger high at that edge starts a sequence.

Verification (bench parameters LIGHT_TICKS=2, MIN_DELAY=4, tick every 3rd clk unless stated)
REQ-028 Reset in idle: rst pulse between edges -> outputs 0, prbs_en=1 before the next edge; no activity without trigger.
REQ-029 Full run with prbs_in=7'h05 at HOLD entry -> lights steps 01,03,07,...,FF every 2 ticks; prbs_en=0; HOLD lasts 9 ticks; then go=1 for 1 cycle with lights=0.
REQ-030 Delay bounds: prbs_in=7'h00 -> HOLD 4 ticks; prbs_in=7'h7F -> HOLD 131 ticks; delay_cnt never wraps.
REQ-031 Simultaneous events: trigger+tick in the same IDLE cycle -> first light held a full 2 ticks; trigger pulses during LIGHTS/HOLD -> no effect; trigger held high -> restart on the edge after go.
REQ-032 Reset mid-operation: rst asserted at lights=8'h0F and again mid-HOLD -> lights=0 asynchronously, go never pulses, next trigger restarts from lights=8'h01.
REQ-033 Back-to-back ticks (tick=1 every cycle) -> LIGHTS lasts 16 cycles, HOLD lasts MIN_DELAY+prbs_in cycles exactly.
